// File: rtl/decoder_4_dispatch_pkg.sv
// decoder_4_dispatch_pkg: shared state encoding and sizing constants for the one-hot dispatcher
package decoder_4_dispatch_pkg;
  typedef enum logic {IDLE, DRIVE} state_e;
  localparam int IDX_W = 2;
  localparam int LINES = 4;
  localparam int DEPTH_DEFAULT = 4;
endpackage

// File: rtl/decoder_4_dispatch_fifo_sync.sv
// fifo_sync: synchronous FIFO with combinational head read and occupancy count
module fifo_sync #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [AW:0]      o_count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  // Power-of-two depth lets the pointers wrap by plain overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(i_push);
    rd_ptr_d = rd_ptr_q + AW'(i_pop);
    count_d = count_q + (AW+1)'(i_push) - (AW+1)'(i_pop);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge i_clk) if (i_push) mem_q[wr_ptr_q] <= i_wdata;
  assign o_rdata = mem_q[rd_ptr_q];
  assign o_count = count_q;
endmodule

// File: rtl/decoder_4_dispatch.sv
// decoder_4_dispatch: buffers encoded indices and drives them out one-hot under a valid/ack handshake
module decoder_4_dispatch
  import decoder_4_dispatch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_index,
  output logic             o_ready,
  output logic [LINES-1:0] o_onehot,
  output logic             o_valid,
  input  logic             i_ack,
  output logic [CW-1:0]    o_count
);
  state_e state_q, state_d;
  logic [LINES-1:0] onehot_q, onehot_d;
  logic [IDX_W-1:0] head;
  logic has, pop, push;
  fifo_sync #(.WIDTH(IDX_W), .DEPTH(DEPTH)) u_fifo (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(push), .i_wdata(i_index),
    .i_pop(pop), .o_rdata(head), .o_count(o_count)
  );
  // Ready comes from registered occupancy only, so a full buffer refuses even during a pop
  assign o_ready = o_count < CW'(DEPTH);
  assign push = i_valid && o_ready;
  assign has = o_count != '0;
  always_comb begin
    pop = (state_q == IDLE || i_ack) && has;
    state_d = (state_q == IDLE || i_ack) ? (has ? DRIVE : IDLE) : state_q;
    onehot_d = (state_q == IDLE || i_ack) ? (has ? LINES'(1) << head : '0) : onehot_q;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      onehot_q <= '0;
    end else begin
      state_q <= state_d;
      onehot_q <= onehot_d;
    end
  end
  assign o_onehot = onehot_q;
  assign o_valid = state_q == DRIVE;
endmodule

// File: tb/tb_decoder_4_dispatch.sv
// tb_decoder_4_dispatch: directed self-checking bench for the one-hot dispatcher
module tb_decoder_4_dispatch;
  logic i_clk = 1'b0;
  logic i_rst_n, i_valid, i_ack, o_ready, o_valid;
  logic [1:0] i_index;
  logic [3:0] o_onehot;
  logic [2:0] o_count;
  int n_checks = 0, n_fail = 0;
  int exp_q[$];
  int seen;
  decoder_4_dispatch #(.DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_index(i_index),
    .o_ready(o_ready), .o_onehot(o_onehot), .o_valid(o_valid), .i_ack(i_ack),
    .o_count(o_count)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic push(input logic [1:0] idx);
    i_valid = 1'b1;
    i_index = idx;
    tick();
    i_valid = 1'b0;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_onehot"}, 32'(o_onehot), 0);
    check({tag, "_valid"}, 32'(o_valid), 0);
    check({tag, "_count"}, 32'(o_count), 0);
    check({tag, "_ready"}, 32'(o_ready), 1);
  endtask
  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_ack = 1'b0; i_index = 2'd0;
    tick(); tick();
    i_rst_n = 1'b1;
    check_idle("reset");
    // single push, latency two cycles, held until ack
    push(2'd2);
    check("single_t1_valid", 32'(o_valid), 0);
    check("single_t1_count", 32'(o_count), 1);
    tick();
    check("single_t2_onehot", 32'(o_onehot), 32'h4);
    check("single_t2_valid", 32'(o_valid), 1);
    tick();
    check("single_hold", 32'(o_onehot), 32'h4);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check_idle("single_done");
    // back-to-back
    push(2'd3); push(2'd0); push(2'd1);
    check("b2b_first", 32'(o_onehot), 32'h8);
    check("b2b_count", 32'(o_count), 2);
    i_ack = 1'b1;
    tick(); check("b2b_second", 32'(o_onehot), 32'h1);
    tick(); check("b2b_third", 32'(o_onehot), 32'h2);
    tick(); i_ack = 1'b0;
    check_idle("b2b_done");
    // fill: one index goes to the output, four fill the buffer, the last is dropped
    push(2'd1); push(2'd2); push(2'd3); push(2'd0); push(2'd1);
    check("full_count", 32'(o_count), 4);
    check("full_ready", 32'(o_ready), 0);
    push(2'd2);
    check("full_drop_count", 32'(o_count), 4);
    check("full_head", 32'(o_onehot), 32'h2);
    i_ack = 1'b1;
    tick(); check("full_d1", 32'(o_onehot), 32'h4);
    tick(); check("full_d2", 32'(o_onehot), 32'h8);
    tick(); check("full_d3", 32'(o_onehot), 32'h1);
    tick(); check("full_d4", 32'(o_onehot), 32'h2);
    tick(); i_ack = 1'b0;
    check_idle("full_done");
    // simultaneous push and pop with two buffered
    push(2'd0); push(2'd1); push(2'd2);
    check("sim_pre_count", 32'(o_count), 2);
    check("sim_pre_onehot", 32'(o_onehot), 32'h1);
    i_ack = 1'b1;
    push(2'd3);
    check("sim_count", 32'(o_count), 2);
    check("sim_onehot", 32'(o_onehot), 32'h2);
    tick(); check("sim_d1", 32'(o_onehot), 32'h4);
    tick(); check("sim_d2", 32'(o_onehot), 32'h8);
    tick(); i_ack = 1'b0;
    check_idle("sim_done");
    // reset mid-operation, asserted together with push and ack
    push(2'd0); push(2'd1); push(2'd2); push(2'd3);
    check("rst_pre_count", 32'(o_count), 3);
    check("rst_pre_valid", 32'(o_valid), 1);
    i_rst_n = 1'b0; i_valid = 1'b1; i_index = 2'd2; i_ack = 1'b1;
    tick();
    i_rst_n = 1'b1; i_valid = 1'b0; i_ack = 1'b0;
    check_idle("rst_now");
    tick(); tick();
    check_idle("rst_no_stale");
    push(2'd3);
    tick();
    check("rst_fresh", 32'(o_onehot), 32'h8);
    check("rst_fresh_count", 32'(o_count), 0);
    i_ack = 1'b1;
    tick();
    check_idle("rst_fresh_done");
    // wrap-around stream with ack held high
    seen = 0;
    for (int i = 0; i < 3 * 4 + 6; i++) begin
      if (o_valid) begin
        check("wrap_onehot_bits", 32'($countones(o_onehot)), 1);
        if (exp_q.size() == 0) check("wrap_extra", 32'(o_onehot), 0);
        else check("wrap_order", 32'(o_onehot), 32'(4'(1) << exp_q.pop_front()));
        seen++;
      end else check("wrap_idle_onehot", 32'(o_onehot), 0);
      i_valid = i < 3 * 4;
      i_index = 2'($urandom_range(0, 3));
      if (i_valid && o_ready) exp_q.push_back(int'(i_index));
      tick();
    end
    i_valid = 1'b0; i_ack = 1'b0;
    check("wrap_seen", 32'(seen), 12);
    check("wrap_left", 32'(exp_q.size()), 0);
    check_idle("wrap_done");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
